// File: rtl/jtag_dma_responder.sv
// Burst DMA responder for JTAG chain-1: moves BURST_WORDS words between the
// ping-pong buffer and a req/ack memory bus. Optional bus-ack timeout: DMA_TIMEOUT_EN.
module jtag_dma_responder #(
  parameter int BURST_WORDS    = 16,
  parameter int BUF_ADDR_W     = 9,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  JTCK,
  input  logic                  JRSTN,
  input  logic [31:0]           dma_address,
  input  logic                  dma_data_ready,
  input  logic [3:0]            dma_byte_enable,
  input  logic                  dma_readReady,
  output logic [BUF_ADDR_W-1:0] buf_address,
  output logic                  buf_writeEnable,
  output logic [31:0]           buf_dataIn,
  input  logic [31:0]           buf_dataOut,
  output logic                  bus_request,
  input  logic                  bus_grant,
  output logic [31:0]           bus_address,
  output logic                  bus_write,
  output logic [3:0]            bus_byte_enable,
  output logic [31:0]           bus_wdata,
  output logic                  bus_valid,
  input  logic                  bus_ack,
  input  logic [31:0]           bus_rdata,
  output logic                  dma_busy,
  output logic                  dma_done,
  output logic                  dma_error
);

  if (BURST_WORDS < 1 || BURST_WORDS > 512 || BURST_WORDS > (1 << BUF_ADDR_W) ||
      TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("jtag_dma_responder: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_BUF_RD, S_BUF_CAP, S_XFER, S_BUF_WR, S_NEXT, S_DONE
  } state_t;

  localparam logic [BUF_ADDR_W-1:0] LAST_WORD = BUF_ADDR_W'(BURST_WORDS - 1);

  state_t                state;
  logic [BUF_ADDR_W-1:0] count;
  logic [BUF_ADDR_W-1:0] count_inc;
  logic [31:0]           base;
  logic [31:0]           cur_word_addr;
  logic [31:0]           next_word_addr;

  // Byte address arithmetic deliberately wraps at 2^32.
  assign count_inc      = count + BUF_ADDR_W'(1);
  assign cur_word_addr  = base + (32'(count) << 2);
  assign next_word_addr = base + (32'(count_inc) << 2);

`ifdef DMA_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt;
`else
  assign dma_error = 1'b0;
`endif

  always_ff @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) begin
      state           <= S_IDLE;
      count           <= '0;
      base            <= '0;
      buf_address     <= '0;
      buf_writeEnable <= 1'b0;
      buf_dataIn      <= '0;
      bus_request     <= 1'b0;
      bus_address     <= '0;
      bus_write       <= 1'b0;
      bus_byte_enable <= '0;
      bus_wdata       <= '0;
      bus_valid       <= 1'b0;
      dma_busy        <= 1'b0;
      dma_done        <= 1'b0;
`ifdef DMA_TIMEOUT_EN
      dma_error       <= 1'b0;
      to_cnt          <= '0;
`endif
    end else begin
      dma_done        <= 1'b0;
      buf_writeEnable <= 1'b0;
`ifdef DMA_TIMEOUT_EN
      if (state != S_XFER) to_cnt <= '0;
`endif
      case (state)
        S_IDLE: begin
          // A simultaneous read request loses to the write.
          if (dma_data_ready || dma_readReady) begin
            state           <= S_REQ;
            count           <= '0;
            base            <= dma_address & ~32'h3;
            bus_write       <= dma_data_ready;
            bus_byte_enable <= dma_data_ready ? dma_byte_enable : 4'hF;
            bus_request     <= 1'b1;
            dma_busy        <= 1'b1;
`ifdef DMA_TIMEOUT_EN
            dma_error       <= 1'b0;
`endif
          end
        end
        S_REQ: begin
          if (bus_grant) begin
            if (bus_write) begin
              state       <= S_BUF_RD;
              buf_address <= count;
            end else begin
              state       <= S_XFER;
              bus_address <= cur_word_addr;
              bus_valid   <= 1'b1;
            end
          end
        end
        S_BUF_RD: state <= S_BUF_CAP;
        S_BUF_CAP: begin
          bus_wdata   <= buf_dataOut;
          bus_address <= cur_word_addr;
          bus_valid   <= 1'b1;
          state       <= S_XFER;
        end
        S_XFER: begin
          if (bus_ack) begin
            bus_valid <= 1'b0;
`ifdef DMA_TIMEOUT_EN
            to_cnt    <= '0;
`endif
            if (bus_write) begin
              state <= S_NEXT;
            end else begin
              state           <= S_BUF_WR;
              buf_address     <= count;
              buf_dataIn      <= bus_rdata;
              buf_writeEnable <= 1'b1;
            end
          end
`ifdef DMA_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            // Abandon the rest of the burst but still report completion.
            bus_valid   <= 1'b0;
            bus_request <= 1'b0;
            dma_error   <= 1'b1;
            dma_done    <= 1'b1;
            state       <= S_DONE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end
        S_BUF_WR: state <= S_NEXT;
        S_NEXT: begin
          if (count == LAST_WORD) begin
            state       <= S_DONE;
            dma_done    <= 1'b1;
            bus_request <= 1'b0;
          end else begin
            count <= count_inc;
            if (bus_write) begin
              state       <= S_BUF_RD;
              buf_address <= count_inc;
            end else begin
              state       <= S_XFER;
              bus_address <= next_word_addr;
              bus_valid   <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          dma_busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_dma_responder.sv
// Self-checking bench for jtag_dma_responder: vector table, hand-written corner
// sequences and randomized bursts against a word-level transfer model.
module tb_jtag_dma_responder;

  localparam int BW = 4;

  logic        JTCK = 1'b0;
  logic        JRSTN = 1'b0;
  logic [31:0] dma_address = '0;
  logic        dma_data_ready = 1'b0;
  logic [3:0]  dma_byte_enable = '0;
  logic        dma_readReady = 1'b0;
  logic [8:0]  buf_address;
  logic        buf_writeEnable;
  logic [31:0] buf_dataIn;
  logic [31:0] buf_dataOut;
  logic        bus_request;
  logic        bus_grant;
  logic [31:0] bus_address;
  logic        bus_write;
  logic [3:0]  bus_byte_enable;
  logic [31:0] bus_wdata;
  logic        bus_valid;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        dma_busy;
  logic        dma_done;
  logic        dma_error;

  always #5 JTCK = ~JTCK;

  jtag_dma_responder #(.BURST_WORDS(BW), .BUF_ADDR_W(9), .TIMEOUT_CYCLES(8)) dut (
    .JTCK(JTCK), .JRSTN(JRSTN),
    .dma_address(dma_address), .dma_data_ready(dma_data_ready),
    .dma_byte_enable(dma_byte_enable), .dma_readReady(dma_readReady),
    .buf_address(buf_address), .buf_writeEnable(buf_writeEnable),
    .buf_dataIn(buf_dataIn), .buf_dataOut(buf_dataOut),
    .bus_request(bus_request), .bus_grant(bus_grant), .bus_address(bus_address),
    .bus_write(bus_write), .bus_byte_enable(bus_byte_enable), .bus_wdata(bus_wdata),
    .bus_valid(bus_valid), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .dma_busy(dma_busy), .dma_done(dma_done), .dma_error(dma_error)
  );

  // Ping-pong buffer port model: registered read, bench-side preload port.
  logic [31:0] bufmem [0:511];
  logic        load_en = 1'b0;
  logic [8:0]  load_idx = '0;
  logic [31:0] load_val = '0;
  always @(posedge JTCK) begin
    if (load_en) bufmem[load_idx] <= load_val;
    else if (buf_writeEnable) bufmem[buf_address] <= buf_dataIn;
    buf_dataOut <= bufmem[buf_address];
  end

  typedef struct { logic [31:0] addr; logic wr; logic [3:0] be; logic [31:0] wdata; } txn_t;
  typedef struct { logic [8:0] a; logic [31:0] d; } bw_t;
  txn_t        txn_q[$];
  bw_t         bw_q[$];
  logic [31:0] rd_tab [0:1023];
  int          dly_tab [0:1023];
  int          hold_at = -1;
  int          done_cnt = 0;
  int          held_cyc = 0;
  int          vwor = 0;
  int          vecs = 0;
  int          errs = 0;

  // Bus slave + monitors, all on the falling edge.
  initial begin
    int wcnt;
    wcnt = 0;
    bus_ack = 1'b0; bus_rdata = '0; bus_grant = 1'b0;
    forever begin
      @(negedge JTCK);
      bus_grant = bus_request;
      if (dma_done) done_cnt++;
      if (buf_writeEnable) bw_q.push_back(bw_t'{buf_address, buf_dataIn});
      if (bus_valid && !bus_request) vwor++;
      if (bus_ack) begin
        bus_ack = 1'b0; wcnt = 0;
      end else if (bus_valid) begin
        if (txn_q.size() == hold_at) held_cyc++;
        else if (wcnt >= dly_tab[txn_q.size() % 1024]) begin
          bus_ack   = 1'b1;
          bus_rdata = rd_tab[txn_q.size() % 1024];
          txn_q.push_back(txn_t'{bus_address, bus_write, bus_byte_enable, bus_wdata});
          $display("txn %0d: addr=%h wr=%0d be=%b wdata=%h rdata=%h", txn_q.size() - 1,
                   bus_address, bus_write, bus_byte_enable, bus_wdata, bus_rdata);
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic preload(input int i, input logic [31:0] v);
    load_idx = i[8:0]; load_val = v; load_en = 1'b1;
    @(negedge JTCK);
    load_en = 1'b0;
  endtask

  task automatic pulse_start(input bit wr, input bit rd, input logic [31:0] a, input logic [3:0] be);
    @(negedge JTCK);
    dma_address = a; dma_byte_enable = be; dma_data_ready = wr; dma_readReady = rd;
    @(negedge JTCK);
    dma_data_ready = 1'b0; dma_readReady = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int  n;
    bit  seen;
    n = 0; seen = 1'b0;
    while (!seen && n < 600) begin
      @(posedge JTCK); #1;
      seen = dma_done;
      n++;
    end
    chk({nm, " done seen"}, 32'(seen), 32'd1);
  endtask

  // Per-word read data and ack delays for the next burst; expected write data snapshot.
  task automatic prep(input bit fixed_rd, input bit rnd_dly, input int dly,
                      output int t0, output int b0, output int d0, output logic [31:0] expd [BW]);
    t0 = txn_q.size(); b0 = bw_q.size(); d0 = done_cnt;
    for (int i = 0; i < BW; i++) begin
      expd[i] = bufmem[i];
      rd_tab[(t0 + i) % 1024]  = fixed_rd ? 32'h11 * 32'(i + 1) : $urandom;
      dly_tab[(t0 + i) % 1024] = rnd_dly ? int'($urandom_range(0, 3)) : dly;
    end
  endtask

  // Reference: word i goes to ((addr & ~3) + 4*i) mod 2^32; reads land in buffer index i.
  task automatic check_burst(input string nm, input bit wr, input logic [31:0] a,
                             input logic [3:0] be, input int t0, input int b0, input int d0,
                             input logic [31:0] expd [BW]);
    int   n;
    txn_t t;
    repeat (3) @(negedge JTCK);
    n = txn_q.size() - t0;
    chk({nm, " txn count"}, 32'(n), 32'(BW));
    for (int i = 0; i < BW && i < n; i++) begin
      t = txn_q[t0 + i];
      chk($sformatf("%s addr%0d", nm, i), t.addr, (a & ~32'h3) + 32'(4 * i));
      chk($sformatf("%s dir%0d", nm, i), 32'(t.wr), 32'(wr));
      chk($sformatf("%s be%0d", nm, i), 32'(t.be), wr ? 32'(be) : 32'hF);
      if (wr) chk($sformatf("%s wdata%0d", nm, i), t.wdata, expd[i]);
    end
    if (!wr) begin
      n = bw_q.size() - b0;
      chk({nm, " bufwr count"}, 32'(n), 32'(BW));
      for (int i = 0; i < BW && i < n; i++) begin
        chk($sformatf("%s bufwr idx%0d", nm, i), 32'(bw_q[b0 + i].a), 32'(i));
        chk($sformatf("%s bufwr dat%0d", nm, i), bw_q[b0 + i].d, rd_tab[(t0 + i) % 1024]);
        chk($sformatf("%s bufmem%0d", nm, i), bufmem[i], rd_tab[(t0 + i) % 1024]);
      end
    end
    chk({nm, " done pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({nm, " busy after"}, 32'(dma_busy), 32'd0);
    chk({nm, " valid w/o req"}, 32'(vwor), 32'd0);
  endtask

  typedef struct {
    bit wr; bit both; logic [31:0] addr; logic [3:0] be; int dly;
    logic [31:0] a0; logic [31:0] a3; logic [3:0] ebe;
  } vec_t;

  initial begin
    vec_t        vt [5];
    logic [31:0] expd [BW];
    int          t0, b0, d0, h0;
    bit          wr;
    logic [31:0] a;
    logic [3:0]  be;

    vt[0] = '{1'b1, 1'b0, 32'h1000_0003, 4'b0101, 2, 32'h1000_0000, 32'h1000_000C, 4'b0101};
    vt[1] = '{1'b0, 1'b0, 32'h2000_0010, 4'b0011, 1, 32'h2000_0010, 32'h2000_001C, 4'hF};
    vt[2] = '{1'b0, 1'b1, 32'h3000_0000, 4'b1110, 0, 32'h3000_0000, 32'h3000_000C, 4'b1110};
    vt[3] = '{1'b1, 1'b0, 32'hFFFF_FFF8, 4'b1000, 3, 32'hFFFF_FFF8, 32'h0000_0004, 4'b1000};
    vt[4] = '{1'b0, 1'b0, 32'hFFFF_FFFA, 4'b0001, 0, 32'hFFFF_FFF8, 32'h0000_0004, 4'hF};

    // Reset state
    repeat (3) @(negedge JTCK);
    chk("rst bus_request", 32'(bus_request), 32'd0);
    chk("rst bus_valid", 32'(bus_valid), 32'd0);
    chk("rst dma_busy", 32'(dma_busy), 32'd0);
    chk("rst dma_done", 32'(dma_done), 32'd0);
    chk("rst buf_we", 32'(buf_writeEnable), 32'd0);
    chk("rst bus_address", bus_address, 32'd0);
    chk("rst dma_error", 32'(dma_error), 32'd0);
    for (int i = 0; i < BW; i++) preload(i, 32'hA0 + 32'(i));
    JRSTN = 1'b1;

    // Table-driven bursts
    for (int v = 0; v < 5; v++) begin
      prep(1'b1, 1'b0, vt[v].dly, t0, b0, d0, expd);
      pulse_start(vt[v].wr | vt[v].both, !vt[v].wr | vt[v].both, vt[v].addr, vt[v].be);
      wait_done($sformatf("vec%0d", v));
      check_burst($sformatf("vec%0d", v), vt[v].wr | vt[v].both, vt[v].addr, vt[v].be,
                  t0, b0, d0, expd);
      if (txn_q.size() >= t0 + BW) begin
        chk($sformatf("vec%0d first addr", v), txn_q[t0].addr, vt[v].a0);
        chk($sformatf("vec%0d last addr", v), txn_q[t0 + BW - 1].addr, vt[v].a3);
        chk($sformatf("vec%0d lanes", v), 32'(txn_q[t0].be), 32'(vt[v].ebe));
      end
    end

    // Read request while busy is ignored
    for (int i = 0; i < BW; i++) preload(i, 32'hB0 + 32'(i));
    prep(1'b0, 1'b0, 1, t0, b0, d0, expd);
    pulse_start(1'b1, 1'b0, 32'h4000_0100, 4'hF);
    repeat (4) @(negedge JTCK);
    dma_readReady = 1'b1;
    @(negedge JTCK);
    dma_readReady = 1'b0;
    wait_done("busyrd");
    check_burst("busyrd", 1'b1, 32'h4000_0100, 4'hF, t0, b0, d0, expd);
    repeat (12) @(negedge JTCK);
    chk("busyrd no extra txn", 32'(txn_q.size() - t0), 32'(BW));
    chk("busyrd request idle", 32'(bus_request), 32'd0);

    // Reset in the middle of a write burst (word 1 held without ack)
    prep(1'b0, 1'b0, 0, t0, b0, d0, expd);
    hold_at = t0 + 1;
    pulse_start(1'b1, 1'b0, 32'h5000_0000, 4'hF);
    for (int n = 0; n < 200; n++) begin
      @(posedge JTCK); #1;
      if (bus_valid && txn_q.size() == hold_at) break;
    end
    chk("midrst reached xfer", 32'(bus_valid), 32'd1);
    #2 JRSTN = 1'b0;
    #1;
    chk("midrst bus_request", 32'(bus_request), 32'd0);
    chk("midrst bus_valid", 32'(bus_valid), 32'd0);
    chk("midrst dma_busy", 32'(dma_busy), 32'd0);
    repeat (3) @(negedge JTCK);
    chk("midrst no done", 32'(done_cnt - d0), 32'd0);
    hold_at = -1;
    JRSTN = 1'b1;
    prep(1'b0, 1'b1, 0, t0, b0, d0, expd);
    pulse_start(1'b1, 1'b0, 32'h5000_0040, 4'b0110);
    wait_done("postrst");
    check_burst("postrst", 1'b1, 32'h5000_0040, 4'b0110, t0, b0, d0, expd);

`ifdef DMA_TIMEOUT_EN
    // Ack withheld on word 1: burst abandoned after 8 cycles of bus_valid
    prep(1'b0, 1'b0, 1, t0, b0, d0, expd);
    hold_at = t0 + 1;
    h0 = held_cyc;
    pulse_start(1'b1, 1'b0, 32'h6000_0000, 4'hF);
    wait_done("timeout");
    repeat (2) @(negedge JTCK);
    chk("timeout txns", 32'(txn_q.size() - t0), 32'd1);
    chk("timeout valid cycles", 32'(held_cyc - h0), 32'd8);
    chk("timeout error", 32'(dma_error), 32'd1);
    chk("timeout done pulses", 32'(done_cnt - d0), 32'd1);
    chk("timeout valid low", 32'(bus_valid), 32'd0);
    chk("timeout request low", 32'(bus_request), 32'd0);
    hold_at = -1;
    prep(1'b0, 1'b0, 0, t0, b0, d0, expd);
    pulse_start(1'b0, 1'b1, 32'h6000_0100, 4'hF);
    chk("timeout error cleared", 32'(dma_error), 32'd0);
    wait_done("aftertimeout");
    check_burst("aftertimeout", 1'b0, 32'h6000_0100, 4'hF, t0, b0, d0, expd);
`else
    h0 = held_cyc;
`endif

    // Randomized bursts against the model
    for (int r = 0; r < 16; r++) begin
      wr = 1'(($urandom_range(0, 1)));
      a  = $urandom;
      be = 4'($urandom_range(0, 15));
      if (wr) for (int i = 0; i < BW; i++) preload(i, $urandom);
      prep(1'b0, 1'b1, 0, t0, b0, d0, expd);
      pulse_start(wr, !wr, a, be);
      wait_done($sformatf("rnd%0d", r));
      check_burst($sformatf("rnd%0d", r), wr, a, be, t0, b0, d0, expd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
